// File: rtl/sap1e_pkg.sv
`default_nettype none
// ============================================================================
// sap1e_pkg : opcode, T-step and control-word definitions for the SAP-1e core
// Rev 1.0
// ============================================================================
package sap1e_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;

  typedef struct packed {
    logic pc_clear;
    logic pc_incr_en;
    logic pc_set;
    logic pc_oe;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/sap1e_sequencer_if.sv
`default_nettype none
// ============================================================================
// sap1e_sequencer_if : sequencer <-> datapath control/status bundle
// Rev 1.0
// ============================================================================
interface sap1e_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int STEPS    = 5
) ();

  logic                restart;
  logic [OPCODE_W-1:0] opcode;
  logic                carry_flag;
  logic                zero_flag;
  logic [STEPS-1:0]    t_state;
  logic                pc_clear;
  logic                pc_incr_en;
  logic                pc_set;
  logic                pc_oe;
  logic                mar_load;
  logic                ram_oe;
  logic                ram_we;
  logic                ir_load;
  logic                ir_oe;
  logic                a_load;
  logic                a_oe;
  logic                b_load;
  logic                alu_oe;
  logic                alu_sub;
  logic                flags_load;
  logic                out_load;
  logic                halted;

  // master = sequencer (drives the control lines), slave = datapath side
  modport master (
    input  restart, opcode, carry_flag, zero_flag,
    output t_state, pc_clear, pc_incr_en, pc_set, pc_oe, mar_load, ram_oe, ram_we,
           ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub, flags_load,
           out_load, halted
  );

  modport slave (
    output restart, opcode, carry_flag, zero_flag,
    input  t_state, pc_clear, pc_incr_en, pc_set, pc_oe, mar_load, ram_oe, ram_we,
           ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub, flags_load,
           out_load, halted
  );

endinterface
`default_nettype wire

// File: rtl/sap1e_ring_counter.sv
`default_nettype none
// ============================================================================
// sap1e_ring_counter : one-hot T-state ring with synchronous clear and hold
// Rev 1.0
// ============================================================================
module sap1e_ring_counter #(
  parameter int STEPS = 5
) (
  input  wire              clock,
  input  wire              reset,
  input  wire              i_clear,
  input  wire              i_hold,
  output logic [STEPS-1:0] o_t_state
);

  localparam logic [STEPS-1:0] c_ring_init = STEPS'(1);

  logic [STEPS-1:0] r_ring;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_ring <= c_ring_init;
    end else if (!i_hold) begin
      r_ring <= {r_ring[STEPS-2:0], r_ring[STEPS-1]};
    end
  end

  assign o_t_state = r_ring;

endmodule
`default_nettype wire

// File: rtl/sap1e_sequencer.sv
`default_nettype none
// ============================================================================
// sap1e_sequencer : SAP-1e T-state sequencer and control decoder.
// Optional macro SEQ_COND_JUMP_EN enables JC/JZ.                       Rev 1.0
// ============================================================================
module sap1e_sequencer
  import sap1e_pkg::*;
#(
  parameter int OPCODE_W = sap1e_pkg::OPCODE_W,
  parameter int STEPS    = 5
) (
  input wire                 clock,
  input wire                 reset,
  sap1e_sequencer_if.master  bus
);

  logic [STEPS-1:0] w_step;
  logic             r_halted;
  logic             w_hlt_now;
  logic             w_hold;
  ctrl_t            w_ctrl;

  // HLT must freeze the ring on the same edge that sets halted, so it stays at T3
  assign w_hlt_now = w_step[T3_IDX] && (bus.opcode == OPCODE_W'(OP_HLT));
  assign w_hold    = r_halted || w_hlt_now;

  sap1e_ring_counter #(
    .STEPS (STEPS)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (bus.restart),
    .i_hold    (w_hold),
    .o_t_state (w_step)
  );

  always_ff @(posedge clock) begin
    if (reset || bus.restart) begin
      r_halted <= 1'b0;
    end else if (w_hlt_now) begin
      r_halted <= 1'b1;
    end
  end

`ifndef SEQ_COND_JUMP_EN
  logic w_unused_flags;
  assign w_unused_flags = bus.carry_flag ^ bus.zero_flag;
`endif

  always_comb begin
    w_ctrl = '0;
    if (!reset) begin
      if (bus.restart) begin
        w_ctrl.pc_clear = 1'b1;
      end else if (!r_halted) begin
        if (w_step[T1_IDX]) begin
          w_ctrl.pc_oe    = 1'b1;
          w_ctrl.mar_load = 1'b1;
        end else if (w_step[T2_IDX]) begin
          w_ctrl.ram_oe     = 1'b1;
          w_ctrl.ir_load    = 1'b1;
          w_ctrl.pc_incr_en = 1'b1;
        end else if (w_step[T3_IDX]) begin
          case (bus.opcode)
            OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD),
            OPCODE_W'(OP_SUB), OPCODE_W'(OP_STA): begin
              w_ctrl.ir_oe    = 1'b1;
              w_ctrl.mar_load = 1'b1;
            end
            OPCODE_W'(OP_LDI): begin
              w_ctrl.ir_oe  = 1'b1;
              w_ctrl.a_load = 1'b1;
            end
            OPCODE_W'(OP_JMP): begin
              w_ctrl.ir_oe  = 1'b1;
              w_ctrl.pc_set = 1'b1;
            end
`ifdef SEQ_COND_JUMP_EN
            OPCODE_W'(OP_JC): begin
              w_ctrl.ir_oe  = 1'b1;
              w_ctrl.pc_set = bus.carry_flag;
            end
            OPCODE_W'(OP_JZ): begin
              w_ctrl.ir_oe  = 1'b1;
              w_ctrl.pc_set = bus.zero_flag;
            end
`endif
            OPCODE_W'(OP_OUT): begin
              w_ctrl.a_oe     = 1'b1;
              w_ctrl.out_load = 1'b1;
            end
            default: ;
          endcase
        end else if (w_step[T4_IDX]) begin
          case (bus.opcode)
            OPCODE_W'(OP_LDA): begin
              w_ctrl.ram_oe = 1'b1;
              w_ctrl.a_load = 1'b1;
            end
            OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
              w_ctrl.ram_oe = 1'b1;
              w_ctrl.b_load = 1'b1;
            end
            OPCODE_W'(OP_STA): begin
              w_ctrl.a_oe   = 1'b1;
              w_ctrl.ram_we = 1'b1;
            end
            default: ;
          endcase
        end else if (w_step[T5_IDX]) begin
          if (bus.opcode == OPCODE_W'(OP_ADD) || bus.opcode == OPCODE_W'(OP_SUB)) begin
            w_ctrl.alu_oe     = 1'b1;
            w_ctrl.a_load     = 1'b1;
            w_ctrl.flags_load = 1'b1;
            w_ctrl.alu_sub    = (bus.opcode == OPCODE_W'(OP_SUB));
          end
        end
      end
    end
  end

  assign bus.t_state    = w_step;
  assign bus.halted     = r_halted;
  assign bus.pc_clear   = w_ctrl.pc_clear;
  assign bus.pc_incr_en = w_ctrl.pc_incr_en;
  assign bus.pc_set     = w_ctrl.pc_set;
  assign bus.pc_oe      = w_ctrl.pc_oe;
  assign bus.mar_load   = w_ctrl.mar_load;
  assign bus.ram_oe     = w_ctrl.ram_oe;
  assign bus.ram_we     = w_ctrl.ram_we;
  assign bus.ir_load    = w_ctrl.ir_load;
  assign bus.ir_oe      = w_ctrl.ir_oe;
  assign bus.a_load     = w_ctrl.a_load;
  assign bus.a_oe       = w_ctrl.a_oe;
  assign bus.b_load     = w_ctrl.b_load;
  assign bus.alu_oe     = w_ctrl.alu_oe;
  assign bus.alu_sub    = w_ctrl.alu_sub;
  assign bus.flags_load = w_ctrl.flags_load;
  assign bus.out_load   = w_ctrl.out_load;

endmodule
`default_nettype wire

// File: tb/tb_sap1e_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sap1e_sequencer : directed + randomized bench for sap1e_sequencer
// Rev 1.0
// ============================================================================
module tb_sap1e_sequencer;

  localparam int STEPS = 5;

`ifdef SEQ_COND_JUMP_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  localparam logic [15:0] K_PC_CLEAR = 16'h0001;
  localparam logic [15:0] K_PC_INC   = 16'h0002;
  localparam logic [15:0] K_PC_SET   = 16'h0004;
  localparam logic [15:0] K_PC_OE    = 16'h0008;
  localparam logic [15:0] K_MAR      = 16'h0010;
  localparam logic [15:0] K_RAM_OE   = 16'h0020;
  localparam logic [15:0] K_RAM_WE   = 16'h0040;
  localparam logic [15:0] K_IR_LOAD  = 16'h0080;
  localparam logic [15:0] K_IR_OE    = 16'h0100;
  localparam logic [15:0] K_A_LOAD   = 16'h0200;
  localparam logic [15:0] K_A_OE     = 16'h0400;
  localparam logic [15:0] K_B_LOAD   = 16'h0800;
  localparam logic [15:0] K_ALU_OE   = 16'h1000;
  localparam logic [15:0] K_ALU_SUB  = 16'h2000;
  localparam logic [15:0] K_FLAGS    = 16'h4000;
  localparam logic [15:0] K_OUT      = 16'h8000;

  logic clock = 1'b0;
  logic reset;
  logic check_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_step = 1;
  bit   m_halted = 1'b0;
  logic [15:0] dut_ctrl;

  always #5 clock = ~clock;

  sap1e_sequencer_if #(.OPCODE_W(4), .STEPS(STEPS)) bus ();

  sap1e_sequencer #(.OPCODE_W(4), .STEPS(STEPS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign dut_ctrl = {bus.out_load, bus.flags_load, bus.alu_sub, bus.alu_oe,
                     bus.b_load, bus.a_oe, bus.a_load, bus.ir_oe,
                     bus.ir_load, bus.ram_we, bus.ram_oe, bus.mar_load,
                     bus.pc_oe, bus.pc_set, bus.pc_incr_en, bus.pc_clear};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Microcode table from the instruction set description
  function automatic logic [15:0] micro(input int step, input int op, input bit c, input bit z);
    logic [15:0] r;
    r = 16'h0;
    case (step)
      1: r = K_PC_OE | K_MAR;
      2: r = K_RAM_OE | K_IR_LOAD | K_PC_INC;
      3: case (op)
           0, 1, 2, 3: r = K_IR_OE | K_MAR;
           4:  r = K_IR_OE | K_A_LOAD;
           5:  r = K_IR_OE | K_PC_SET;
           6:  r = COND ? (K_IR_OE | (c ? K_PC_SET : 16'h0)) : 16'h0;
           7:  r = COND ? (K_IR_OE | (z ? K_PC_SET : 16'h0)) : 16'h0;
           14: r = K_A_OE | K_OUT;
           default: r = 16'h0;
         endcase
      4: case (op)
           0:    r = K_RAM_OE | K_A_LOAD;
           1, 2: r = K_RAM_OE | K_B_LOAD;
           3:    r = K_A_OE | K_RAM_WE;
           default: r = 16'h0;
         endcase
      5: case (op)
           1: r = K_ALU_OE | K_A_LOAD | K_FLAGS;
           2: r = K_ALU_OE | K_A_LOAD | K_FLAGS | K_ALU_SUB;
           default: r = 16'h0;
         endcase
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset || bus.restart) begin
      m_step   = 1;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_step == 3 && bus.opcode == 4'hF) m_halted = 1'b1;
      else m_step = (m_step == STEPS) ? 1 : m_step + 1;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      logic [15:0] exp_ctrl;
      if (reset)            exp_ctrl = 16'h0;
      else if (bus.restart) exp_ctrl = K_PC_CLEAR;
      else if (m_halted)    exp_ctrl = 16'h0;
      else exp_ctrl = micro(m_step, int'(bus.opcode), bus.carry_flag, bus.zero_flag);
      chk("model_t_state", 32'(bus.t_state), 32'(5'b00001 << (m_step - 1)));
      chk("model_halted", 32'(bus.halted), 32'(m_halted));
      chk("model_ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
      chk("pc_exclusive", 32'($countones({bus.pc_set, bus.pc_incr_en, bus.pc_clear}) <= 1), 32'd1);
      chk("bus_single_drv",
          32'($countones({bus.pc_oe, bus.ram_oe, bus.ir_oe, bus.a_oe, bus.alu_oe}) <= 1), 32'd1);
    end
  end

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.restart = 1'b0;
    bus.opcode = 4'h0;
    bus.carry_flag = 1'b0;
    bus.zero_flag = 1'b0;

    go(1);
    check_en = 1'b1;
    @(negedge clock);
    chk("reset_ctrl", 32'(dut_ctrl), 32'h0);
    chk("reset_t_state", 32'(bus.t_state), 32'h01);

    // JMP
    go(1); reset = 1'b0; bus.opcode = 4'h5;
    @(negedge clock);
    chk("t1_ctrl", 32'(dut_ctrl), 32'(K_PC_OE | K_MAR));
    chk("t1_t_state", 32'(bus.t_state), 32'h01);
    chk("t1_halted", 32'(bus.halted), 32'h0);
    go(1); @(negedge clock);
    chk("t2_ctrl", 32'(dut_ctrl), 32'(K_RAM_OE | K_IR_LOAD | K_PC_INC));
    go(1); @(negedge clock);
    chk("jmp_t3_ctrl", 32'(dut_ctrl), 32'(K_IR_OE | K_PC_SET));
    go(1); @(negedge clock);
    chk("jmp_t4_ctrl", 32'(dut_ctrl), 32'h0);
    go(1); @(negedge clock);
    chk("jmp_t5_ctrl", 32'(dut_ctrl), 32'h0);
    go(1); @(negedge clock);
    chk("jmp_wrap_t1", 32'(bus.t_state), 32'h01);

    // SUB
    go(1); bus.opcode = 4'h2;
    go(3); @(negedge clock);
    chk("sub_t5_t_state", 32'(bus.t_state), 32'h10);
    chk("sub_t5_ctrl", 32'(dut_ctrl), 32'(K_ALU_OE | K_A_LOAD | K_FLAGS | K_ALU_SUB));

    // HLT then restart
    go(1); bus.opcode = 4'hF;
    go(2); @(negedge clock);
    chk("hlt_t3_ctrl", 32'(dut_ctrl), 32'h0);
    chk("hlt_t3_halted", 32'(bus.halted), 32'h0);
    for (int i = 0; i < 10; i++) begin
      go(1); @(negedge clock);
      chk("halted_flag", 32'(bus.halted), 32'h1);
      chk("halted_t_state", 32'(bus.t_state), 32'h04);
      chk("halted_ctrl", 32'(dut_ctrl), 32'h0);
    end
    go(1); bus.restart = 1'b1;
    @(negedge clock);
    chk("restart_ctrl", 32'(dut_ctrl), 32'(K_PC_CLEAR));
    go(1); bus.restart = 1'b0;
    @(negedge clock);
    chk("restart_t_state", 32'(bus.t_state), 32'h01);
    chk("restart_halted", 32'(bus.halted), 32'h0);

    // Conditional jumps
    bus.opcode = 4'h6; bus.carry_flag = 1'b0;
    go(2); @(negedge clock);
    chk("jc_nc_t3_ctrl", 32'(dut_ctrl), COND ? 32'(K_IR_OE) : 32'h0);
    go(3); bus.opcode = 4'h7; bus.zero_flag = 1'b1;
    go(2); @(negedge clock);
    chk("jz_z_t3_ctrl", 32'(dut_ctrl), COND ? 32'(K_IR_OE | K_PC_SET) : 32'h0);

    // Reset during T4 of ADD, then reset together with restart
    go(3); bus.opcode = 4'h1;
    go(3); reset = 1'b1;
    @(negedge clock);
    chk("add_t4_reset_t_state", 32'(bus.t_state), 32'h08);
    chk("add_t4_reset_ctrl", 32'(dut_ctrl), 32'h0);
    go(1); reset = 1'b0;
    @(negedge clock);
    chk("after_reset_t_state", 32'(bus.t_state), 32'h01);
    go(1); reset = 1'b1; bus.restart = 1'b1;
    @(negedge clock);
    chk("rst_restart_ctrl", 32'(dut_ctrl), 32'h0);
    go(1); reset = 1'b0; bus.restart = 1'b0;
    @(negedge clock);
    chk("rst_restart_t_state", 32'(bus.t_state), 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      go(1);
      reset          = ($urandom_range(0, 63) == 0);
      bus.restart    = ($urandom_range(0, 19) == 0);
      bus.opcode     = 4'($urandom_range(0, 15));
      bus.carry_flag = 1'($urandom_range(0, 1));
      bus.zero_flag  = 1'($urandom_range(0, 1));
    end
    go(1);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
